// File: rtl/dac_spi_tx_if.sv
// Sample stream handshake between an audio producer and the DAC serialiser.
// The producer holds SAMPLE_in/SAMPLE_valid stable until SAMPLE_ready completes the transfer.
interface dac_spi_tx_if;
    logic [11:0] SAMPLE_in;
    logic        SAMPLE_valid;
    logic        SAMPLE_ready;

    modport master (
        output SAMPLE_in,
        output SAMPLE_valid,
        input  SAMPLE_ready
    );

    modport slave (
        input  SAMPLE_in,
        input  SAMPLE_valid,
        output SAMPLE_ready
    );
endinterface

// File: rtl/dac_spi_tx.sv
// Double-buffered 12-bit sample serialiser for a DAC121S101 (Pmod DA2) over 3-wire SPI.
// A holding register feeds a 16-bit frame shifter; SCLK idles high and DIN moves on SCLK rises.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [1:0]  PD_MODE = 2'b00
) (
    input  logic        CLK,
    input  logic        RESET,
    dac_spi_tx_if.slave smp,
    output logic        DAC_SYNC,
    output logic        DAC_SCLK,
    output logic        DAC_DIN,
    output logic        BUSY,
    output logic        FRAME_done
);
    localparam int unsigned        DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned        GAP_W    = $clog2(2 * CLK_DIV + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // DAC frame layout: two don't-care zeros, power-down mode, then the sample.
    function automatic logic [15:0] build_frame(input logic [11:0] sample);
        build_frame = {2'b00, PD_MODE, sample};
    endfunction

    state_t           state_r;
    logic [11:0]      hold_r;
    logic             ready_r;
    logic [14:0]      shift_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [4:0]       bit_cnt_r;
    logic             sync_r;
    logic             sclk_r;
    logic             din_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             load_s;
    logic             div_tc_s;
    logic [15:0]      frame_s;

    // Handshake, half-period terminal count and the hold->shifter move condition.
    always_comb begin
        accept_s = smp.SAMPLE_valid & ready_r;
        div_tc_s = (div_cnt_r == DIV_LAST);
        frame_s  = build_frame(hold_r);
        load_s   = 1'b0;
        case (state_r)
            ST_IDLE: load_s = ~ready_r;
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    load_s = ~ready_r;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: load_s = 1'b0;
        endcase
    end

    // Frame FSM, holding register and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            hold_r    <= 12'h000;
            ready_r   <= 1'b1;
            shift_r   <= 15'h0000;
            div_cnt_r <= {DIV_W{1'b0}};
            gap_cnt_r <= {GAP_W{1'b0}};
            bit_cnt_r <= 5'd0;
            sync_r    <= 1'b1;
            sclk_r    <= 1'b1;
            din_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                hold_r <= smp.SAMPLE_in;
            end
            // Ready and full are mutually exclusive, so accept and load never coincide here.
            if (accept_s) begin
                ready_r <= 1'b0;
            end else if (load_s) begin
                ready_r <= 1'b1;
            end
            if (load_s) begin
                shift_r   <= frame_s[14:0];
                din_r     <= frame_s[15];
                sync_r    <= 1'b0;
                busy_r    <= 1'b1;
                div_cnt_r <= {DIV_W{1'b0}};
                bit_cnt_r <= 5'd0;
                state_r   <= ST_SHIFT;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        busy_r <= 1'b0;
                    end
                    ST_SHIFT: begin
                        if (div_tc_s) begin
                            div_cnt_r <= {DIV_W{1'b0}};
                            sclk_r    <= ~sclk_r;
                            if (sclk_r) begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end else if (bit_cnt_r == 5'd16) begin
                                // Rise after the 16th fall closes the frame.
                                sync_r    <= 1'b1;
                                din_r     <= 1'b0;
                                done_r    <= 1'b1;
                                gap_cnt_r <= {GAP_W{1'b0}};
                                state_r   <= ST_GAP;
                            end else begin
                                din_r   <= shift_r[14];
                                shift_r <= {shift_r[13:0], 1'b0};
                            end
                        end else begin
                            div_cnt_r <= div_cnt_r + DIV_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_r == GAP_LAST) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                        end
                    end
                    default: begin
                        sync_r  <= 1'b1;
                        sclk_r  <= 1'b1;
                        din_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign smp.SAMPLE_ready = ready_r;
    assign DAC_SYNC         = sync_r;
    assign DAC_SCLK         = sclk_r;
    assign DAC_DIN          = din_r;
    assign BUSY             = busy_r;
    assign FRAME_done       = done_r;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: a DAC-side model captures DIN on SCLK falls while SYNC is low.
// Instance a uses CLK_DIV=4/PD_MODE=00, instance b uses CLK_DIV=1/PD_MODE=11.
module tb_dac_spi_tx;
    logic CLK = 1'b0;
    logic rst_a;
    logic rst_b;
    logic sync_a, sclk_a, din_a, busy_a, done_a;
    logic sync_b, sclk_b, din_b, busy_b, done_b;

    dac_spi_tx_if ia ();
    dac_spi_tx_if ib ();

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    dac_spi_tx #(.CLK_DIV(4), .PD_MODE(2'b00)) dut_a (
        .CLK(CLK), .RESET(rst_a), .smp(ia),
        .DAC_SYNC(sync_a), .DAC_SCLK(sclk_a), .DAC_DIN(din_a),
        .BUSY(busy_a), .FRAME_done(done_a)
    );

    dac_spi_tx #(.CLK_DIV(1), .PD_MODE(2'b11)) dut_b (
        .CLK(CLK), .RESET(rst_b), .smp(ib),
        .DAC_SYNC(sync_b), .DAC_SCLK(sclk_b), .DAC_DIN(din_b),
        .BUSY(busy_b), .FRAME_done(done_b)
    );

    // DAC-side model state
    logic        pa_sync = 1'b1, pa_sclk = 1'b1, pb_sync = 1'b1, pb_sclk = 1'b1;
    logic [15:0] cap_a, cap_b;
    int          falls_a, low_a, high_a, done_cnt_a, syncfall_a;
    int          low_b, done_cnt_b;
    bit          seen_rise_a;
    logic [15:0] words_a[$];
    int          lows_a[$];
    int          fallsq_a[$];
    int          gaps_a[$];
    logic [15:0] words_b[$];
    int          lows_b[$];

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic clr_a();
        words_a.delete(); lows_a.delete(); fallsq_a.delete(); gaps_a.delete();
        cap_a = 16'h0000; falls_a = 0; low_a = 0; high_a = 0;
        done_cnt_a = 0; syncfall_a = 0; seen_rise_a = 1'b0;
    endtask

    task automatic clr_b();
        words_b.delete(); lows_b.delete();
        cap_b = 16'h0000; low_b = 0; done_cnt_b = 0;
    endtask

    // One clock: wait past the falling edge, then update the DAC model from the settled outputs.
    task automatic tick();
        @(negedge CLK);
        #1;
        if (done_a === 1'b1) done_cnt_a++;
        if (sync_a === 1'b0 && pa_sync === 1'b1) begin
            syncfall_a++;
            if (seen_rise_a) gaps_a.push_back(high_a);
            low_a = 0; falls_a = 0; cap_a = 16'h0000;
        end
        if (sync_a === 1'b1 && pa_sync === 1'b0) begin
            words_a.push_back(cap_a); lows_a.push_back(low_a); fallsq_a.push_back(falls_a);
            seen_rise_a = 1'b1; high_a = 0;
        end
        if (sync_a === 1'b0) begin
            low_a++;
            if (pa_sclk === 1'b1 && sclk_a === 1'b0) begin
                cap_a = {cap_a[14:0], din_a};
                falls_a++;
            end
        end else begin
            high_a++;
        end
        pa_sync = sync_a; pa_sclk = sclk_a;

        if (done_b === 1'b1) done_cnt_b++;
        if (sync_b === 1'b0 && pb_sync === 1'b1) begin
            low_b = 0; cap_b = 16'h0000;
        end
        if (sync_b === 1'b1 && pb_sync === 1'b0) begin
            words_b.push_back(cap_b); lows_b.push_back(low_b);
        end
        if (sync_b === 1'b0) begin
            low_b++;
            if (pb_sclk === 1'b1 && sclk_b === 1'b0) cap_b = {cap_b[14:0], din_b};
        end
        pb_sync = sync_b; pb_sclk = sclk_b;
    endtask

    // Offer a sample, wait (bounded) for ready, let the transfer edge pass, drop valid.
    task automatic send_a(input logic [11:0] s, output int w);
        ia.SAMPLE_in = s; ia.SAMPLE_valid = 1'b1; w = 0;
        while (ia.SAMPLE_ready !== 1'b1 && w < 400) begin tick(); w++; end
        chk_bit("send_a_ready_seen", ia.SAMPLE_ready, 1'b1);
        tick();
        ia.SAMPLE_valid = 1'b0;
    endtask

    task automatic send_b(input logic [11:0] s);
        int w;
        ib.SAMPLE_in = s; ib.SAMPLE_valid = 1'b1; w = 0;
        while (ib.SAMPLE_ready !== 1'b1 && w < 400) begin tick(); w++; end
        chk_bit("send_b_ready_seen", ib.SAMPLE_ready, 1'b1);
        tick();
        ib.SAMPLE_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy_a !== 1'b0 && n < 1000) begin tick(); n++; end
        chk_bit("wait_idle_a", busy_a, 1'b0);
    endtask

    initial begin
        int w;
        int n;
        rst_a = 1'b1; rst_b = 1'b1;
        ia.SAMPLE_in = 12'h000; ia.SAMPLE_valid = 1'b0;
        ib.SAMPLE_in = 12'h000; ib.SAMPLE_valid = 1'b0;
        clr_a(); clr_b();

        // T1 reset values
        repeat (3) tick();
        chk_bit("t1_sync", sync_a, 1'b1);
        chk_bit("t1_sclk", sclk_a, 1'b1);
        chk_bit("t1_din", din_a, 1'b0);
        chk_bit("t1_ready", ia.SAMPLE_ready, 1'b1);
        chk_bit("t1_busy", busy_a, 1'b0);
        chk_bit("t1_done", done_a, 1'b0);

        // Reset dominates a handshake on the same edge
        ia.SAMPLE_in = 12'h7E7; ia.SAMPLE_valid = 1'b1;
        tick();
        rst_a = 1'b0; rst_b = 1'b0; ia.SAMPLE_valid = 1'b0;
        repeat (10) tick();
        chk_bit("rst_dom_ready", ia.SAMPLE_ready, 1'b1);
        chk_int("rst_dom_no_frame", syncfall_a, 0);

        // T2 single frame
        clr_a();
        send_a(12'hA5C, w);
        chk_bit("t2_sync_before", sync_a, 1'b1);
        chk_bit("t2_ready_full", ia.SAMPLE_ready, 1'b0);
        tick();
        chk_bit("t2_sync_low", sync_a, 1'b0);
        chk_bit("t2_busy", busy_a, 1'b1);
        chk_bit("t2_ready_back", ia.SAMPLE_ready, 1'b1);
        n = 0;
        while (done_a !== 1'b1 && n < 300) begin tick(); n++; end
        chk_bit("t2_done_seen", done_a, 1'b1);
        n = 0;
        while (busy_a !== 1'b0 && n < 50) begin tick(); n++; end
        chk_int("t2_busy_tail", n, 8);
        chk_int("t2_nframes", words_a.size(), 1);
        chk_word("t2_word", words_a[0], 16'h0A5C);
        chk_int("t2_sync_low_len", lows_a[0], 128);
        chk_int("t2_falls", fallsq_a[0], 16);
        chk_int("t2_done_pulses", done_cnt_a, 1);

        // T3 back-to-back
        repeat (5) tick();
        clr_a();
        send_a(12'hFFF, w);
        chk_int("t3_wait1", w, 0);
        send_a(12'h001, w);
        chk_int("t3_wait2", w, 1);
        chk_bit("t3_accept_in_frame", sync_a, 1'b0);
        n = 0;
        while (words_a.size() < 2 && n < 600) begin tick(); n++; end
        wait_idle_a();
        chk_int("t3_nframes", words_a.size(), 2);
        chk_word("t3_word0", words_a[0], 16'h0FFF);
        chk_word("t3_word1", words_a[1], 16'h0001);
        chk_int("t3_gap", gaps_a[0], 8);
        chk_int("t3_period", lows_a[0] + gaps_a[0], 136);
        chk_int("t3_low1", lows_a[1], 128);
        chk_int("t3_done_pulses", done_cnt_a, 2);

        // T4 backpressure with three samples offered continuously
        repeat (5) tick();
        clr_a();
        send_a(12'h111, w);
        send_a(12'h222, w);
        chk_bit("t4_third_blocked", ia.SAMPLE_ready, 1'b0);
        send_a(12'h333, w);
        chk_int("t4_third_wait", w, 135);
        n = 0;
        while (words_a.size() < 3 && n < 800) begin tick(); n++; end
        wait_idle_a();
        repeat (20) tick();
        chk_int("t4_nframes", words_a.size(), 3);
        chk_word("t4_word0", words_a[0], 16'h0111);
        chk_word("t4_word1", words_a[1], 16'h0222);
        chk_word("t4_word2", words_a[2], 16'h0333);
        chk_int("t4_done_pulses", done_cnt_a, 3);

        // T5 reset after the 5th SCLK fall, with a second sample held
        clr_a();
        send_a(12'h456, w);
        send_a(12'h789, w);
        n = 0;
        while (falls_a < 5 && n < 300) begin tick(); n++; end
        chk_int("t5_fall5", falls_a, 5);
        rst_a = 1'b1;
        tick();
        chk_bit("t5_sync", sync_a, 1'b1);
        chk_bit("t5_sclk", sclk_a, 1'b1);
        chk_bit("t5_din", din_a, 1'b0);
        chk_bit("t5_ready", ia.SAMPLE_ready, 1'b1);
        chk_bit("t5_busy", busy_a, 1'b0);
        chk_bit("t5_done", done_a, 1'b0);
        rst_a = 1'b0;
        repeat (300) tick();
        chk_int("t5_no_done", done_cnt_a, 0);
        chk_int("t5_held_dropped", syncfall_a, 1);
        chk_bit("t5_ready_after", ia.SAMPLE_ready, 1'b1);

        // T6 PD_MODE=11, CLK_DIV=1
        clr_b();
        send_b(12'h123);
        n = 0;
        while (words_b.size() < 1 && n < 200) begin tick(); n++; end
        repeat (5) tick();
        chk_int("t6_nframes", words_b.size(), 1);
        chk_word("t6_word", words_b[0], 16'h3123);
        chk_int("t6_sync_low_len", lows_b[0], 32);
        chk_int("t6_done_pulses", done_cnt_b, 1);
        chk_bit("t6_idle", busy_b, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
